// File: rtl/mem_read_arb_pkg.sv
// Shared types and constants for the memory read arbiter: request/response records,
// the AXI read-channel bundles and the arbiter FSM state encoding.
package mem_read_arb_pkg;

   localparam int unsigned MAX_CH = 8;
   localparam int unsigned ID_W   = 8;

   localparam logic [1:0] AR_BURST = 2'b10;
   localparam logic       AR_LOCK  = 1'b0;
   localparam logic [3:0] AR_CACHE = 4'b0000;
   localparam logic [2:0] AR_PROT  = 3'b000;

   typedef struct packed {
      logic [31:0] startaddr;
      logic [31:0] va;
      logic [7:0]  len;
      logic [2:0]  size;
   } mem_read_req;

   // valid has one bit per channel; bits at or above N_CH are always zero
   typedef struct packed {
      logic [31:0]       data;
      logic              last;
      logic [31:0]       firstaddr;
      logic [31:0]       firstva;
      logic [MAX_CH-1:0] valid;
   } mem_read_resp;

   typedef struct packed {
      logic [31:0]     araddr;
      logic [ID_W-1:0] arid;
      logic [7:0]      arlen;
      logic [2:0]      arsize;
      logic [1:0]      arburst;
      logic            arlock;
      logic [3:0]      arcache;
      logic [2:0]      arprot;
      logic            arvalid;
      logic            rready;
   } axi_r_req;

   typedef struct packed {
      logic            arready;
      logic [31:0]     rdata;
      logic [ID_W-1:0] rid;
      logic [1:0]      rresp;
      logic            rlast;
      logic            rvalid;
   } axi_r_resp;

   typedef enum logic [1:0] {
      StIdle,
      StArWait,
      StAr,
      StR
   } arb_state_e;

endpackage

// File: rtl/mem_read_chan_fifo.sv
// Per-channel synchronous request queue; push is ignored while full, head is the oldest entry.
module mem_read_chan_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 75
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mem_read_arb.sv
// Multi-channel AXI read arbiter with one outstanding burst and a write-line hazard hold.
// Define MEM_READ_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module mem_read_arb
   import mem_read_arb_pkg::*;
#(
   parameter int unsigned N_CH             = 2,
   parameter int unsigned FIFO_DEPTH       = 8,
   parameter int unsigned SEQ_W            = 3,
   parameter int unsigned LINE_BYTE_OFFSET = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  mem_read_req       i_req [N_CH],
   input  logic [N_CH-1:0]   i_req_valid,
   output logic [N_CH-1:0]   o_req_ready,
   input  logic [N_CH-1:0]   i_stall,
   input  logic              i_write_process,
   input  logic [31:0]       i_write_address,
   output mem_read_resp      o_resp,
   output logic [N_CH-1:0]   o_start,
   output logic [N_CH-1:0]   o_end,
   output logic [N_CH-1:0]   o_empty,
   output axi_r_req          axi_bus_req,
   input  axi_r_resp         axi_bus_resp
);

   localparam int unsigned CH_W = $clog2(N_CH);

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [31:0]       firstaddr_q, firstaddr_d;
   logic [31:0]       firstva_q, firstva_d;
   logic [SEQ_W-1:0]  seq_q [N_CH];
   logic [N_CH-1:0]   end_q;

   mem_read_req       head [N_CH];
   mem_read_req       head_sel;
   logic [N_CH-1:0]   full, empty;
   logic [N_CH-1:0]   pop_vec, start_vec, resp_valid;
   logic              arvalid, hazard;
   logic              arb_found;
   logic [CH_W-1:0]   arb_idx;
   logic              unused_bits;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      mem_read_chan_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH ($bits(mem_read_req))
      ) u_fifo (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .push  (i_req_valid[g]),
         .wdata (i_req[g]),
         .pop   (pop_vec[g]),
         .rdata (head[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   assign head_sel = head[grant_q];
   assign hazard   = i_write_process &&
      (i_write_address[31:LINE_BYTE_OFFSET] == head_sel.startaddr[31:LINE_BYTE_OFFSET]);

`ifdef MEM_READ_ARB_FIXED_PRIO_EN
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!empty[i]) begin
            arb_found = 1'b1;
            arb_idx   = CH_W'(i);
         end
      end
   end
`else
   logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CH_W:0]   rr_sum;

   // Scan downwards so the candidate closest to rr_ptr_q is written last and wins
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      rr_sum    = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         rr_sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
         if (rr_sum >= (CH_W + 1)'(N_CH)) rr_sum = rr_sum - (CH_W + 1)'(N_CH);
         if (!empty[rr_sum[CH_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = rr_sum[CH_W-1:0];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == StIdle && arb_found) begin
         rr_ptr_d = (arb_idx == CH_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      firstaddr_d = firstaddr_q;
      firstva_d   = firstva_q;
      pop_vec     = '0;
      start_vec   = '0;
      resp_valid  = '0;
      arvalid     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_d = arb_idx;
               state_d = StArWait;
            end
         end
         StArWait: begin
            if (!i_stall[grant_q] && !hazard) state_d = StAr;
         end
         StAr: begin
            arvalid = 1'b1;
            if (axi_bus_resp.arready) begin
               start_vec[grant_q] = 1'b1;
               firstaddr_d        = head_sel.startaddr;
               firstva_d          = head_sel.va;
               state_d            = StR;
            end
         end
         StR: begin
            if (axi_bus_resp.rvalid) begin
               resp_valid[grant_q] = 1'b1;
               firstaddr_d         = firstaddr_q + 32'd4;
               firstva_d           = firstva_q + 32'd4;
               if (axi_bus_resp.rlast) begin
                  pop_vec[grant_q] = 1'b1;
                  state_d          = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         firstaddr_q <= '0;
         firstva_q   <= '0;
         end_q       <= '0;
         for (int i = 0; i < N_CH; i++) seq_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         firstaddr_q <= firstaddr_d;
         firstva_q   <= firstva_d;
         end_q       <= pop_vec;
         for (int i = 0; i < N_CH; i++) begin
            if (pop_vec[i]) seq_q[i] <= seq_q[i] + 1'b1;
         end
      end
   end

   assign o_req_ready = ~full;
   assign o_empty     = empty;
   assign o_start     = start_vec;
   assign o_end       = end_q;

   assign o_resp.data      = axi_bus_resp.rdata;
   assign o_resp.last      = axi_bus_resp.rlast;
   assign o_resp.firstaddr = firstaddr_q;
   assign o_resp.firstva   = firstva_q;
   assign o_resp.valid     = MAX_CH'(resp_valid);

   assign axi_bus_req.araddr  = head_sel.startaddr;
   assign axi_bus_req.arid    = ID_W'({grant_q, seq_q[grant_q]});
   assign axi_bus_req.arlen   = head_sel.len;
   assign axi_bus_req.arsize  = head_sel.size;
   assign axi_bus_req.arburst = AR_BURST;
   assign axi_bus_req.arlock  = AR_LOCK;
   assign axi_bus_req.arcache = AR_CACHE;
   assign axi_bus_req.arprot  = AR_PROT;
   assign axi_bus_req.arvalid = arvalid;
   assign axi_bus_req.rready  = 1'b1;

   assign unused_bits = ^{axi_bus_resp.rid, axi_bus_resp.rresp,
                          i_write_address[LINE_BYTE_OFFSET-1:0]};

endmodule

// File: tb/tb_mem_read_arb.sv
// Directed bench for mem_read_arb: latency, arbitration order, hazard/stall hold,
// queue full, seq wrap and mid-burst reset, with a small AXI read slave driven inline.
module tb_mem_read_arb;
   import mem_read_arb_pkg::*;

   localparam int unsigned N_CH  = 2;
   localparam int unsigned SEQ_W = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   mem_read_req     req [N_CH];
   logic [N_CH-1:0] req_valid, req_ready, stall, start, end_pulse, empty;
   logic            write_process;
   logic [31:0]     write_address;
   mem_read_resp    resp;
   axi_r_req        axi_req;
   axi_r_resp       axi_resp;

   int total = 0;
   int bad   = 0;
   int exp_seq [N_CH];

   mem_read_arb #(
      .N_CH             (N_CH),
      .FIFO_DEPTH       (8),
      .SEQ_W            (SEQ_W),
      .LINE_BYTE_OFFSET (6)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req           (req),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_stall         (stall),
      .i_write_process (write_process),
      .i_write_address (write_address),
      .o_resp          (resp),
      .o_start         (start),
      .o_end           (end_pulse),
      .o_empty         (empty),
      .axi_bus_req     (axi_req),
      .axi_bus_resp    (axi_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N_CH; i++) exp_seq[i] = 0;
   endtask

   task automatic set_req(input int ch, input logic [31:0] addr, input logic [7:0] len);
      req[ch].startaddr = addr;
      req[ch].va        = addr ^ 32'hF000_0000;
      req[ch].len       = len;
      req[ch].size      = 3'd2;
      req_valid[ch]     = 1'b1;
   endtask

   task automatic wait_ar();
      int n = 0;
      while (axi_req.arvalid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ar_seen", axi_req.arvalid, 1);
   endtask

   // Waits for AR, checks it, then returns nbeats of read data and checks each beat
   task automatic serve(input int ch, input logic [31:0] addr, input int nbeats);
      logic [31:0] va;
      va = addr ^ 32'hF000_0000;
      wait_ar();
      if (axi_req.arvalid !== 1'b1) return;
      chk("araddr", axi_req.araddr, addr);
      chk("arid", axi_req.arid, (ch << SEQ_W) | exp_seq[ch]);
      chk("arlen", axi_req.arlen, nbeats - 1);
      chk("arburst", axi_req.arburst, 2'b10);
      axi_resp.arready = 1'b1;
      #1 chk("o_start", start, 64'(1) << ch);
      @(negedge clk);
      axi_resp.arready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         axi_resp.rvalid = 1'b1;
         axi_resp.rlast  = (b == nbeats - 1);
         axi_resp.rdata  = 32'hA500_0000 + b;
         #1;
         chk("resp_valid", resp.valid, 64'(1) << ch);
         chk("firstaddr", resp.firstaddr, addr + 4 * b);
         chk("firstva", resp.firstva, va + 4 * b);
         @(negedge clk);
      end
      axi_resp.rvalid = 1'b0;
      axi_resp.rlast  = 1'b0;
      #1 chk("o_end", end_pulse, 64'(1) << ch);
      exp_seq[ch] = (exp_seq[ch] + 1) % (1 << SEQ_W);
      @(negedge clk);
      chk("o_end_once", end_pulse, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N_CH; i++) req[i] = '0;
      req_valid     = '0;
      stall         = '0;
      write_process = 1'b0;
      write_address = '0;
      axi_resp      = '0;

      // Reset state
      do_reset();
      chk("rst_arvalid", axi_req.arvalid, 0);
      chk("rst_empty", empty, 2'b11);
      chk("rst_ready", req_ready, 2'b11);
      chk("rst_start", start, 0);
      chk("rst_end", end_pulse, 0);
      chk("rst_valid", resp.valid, 0);
      chk("rst_rready", axi_req.rready, 1);

      // Single 16-beat burst on ch0 with minimum latency
      set_req(0, 32'h1000, 8'd15);
      @(negedge clk);
      req_valid = '0;
      chk("lat_empty", empty, 2'b10);
      chk("lat_e0", axi_req.arvalid, 0);
      @(negedge clk);
      chk("lat_e1", axi_req.arvalid, 0);
      @(negedge clk);
      chk("lat_e2", axi_req.arvalid, 1);
      serve(0, 32'h1000, 16);
      chk("single_empty", empty, 2'b11);

      // Both channels pending
      do_reset();
      set_req(0, 32'h0100, 8'd0);
      set_req(1, 32'h0200, 8'd0);
      @(negedge clk);
      set_req(0, 32'h0140, 8'd0);
      set_req(1, 32'h0240, 8'd0);
      @(negedge clk);
      req_valid = '0;
`ifdef MEM_READ_ARB_FIXED_PRIO_EN
      serve(1, 32'h0200, 1);
      serve(1, 32'h0240, 1);
      serve(0, 32'h0100, 1);
      serve(0, 32'h0140, 1);
`else
      serve(0, 32'h0100, 1);
      serve(1, 32'h0200, 1);
      serve(0, 32'h0140, 1);
      serve(1, 32'h0240, 1);
`endif

      // Write to the same cache line holds AR until the write drops
      write_process = 1'b1;
      write_address = 32'h1004;
      set_req(0, 32'h1020, 8'd0);
      @(negedge clk);
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         chk("hazard_hold", axi_req.arvalid, 0);
         @(negedge clk);
      end
      write_process = 1'b0;
      @(negedge clk);
      chk("hazard_release", axi_req.arvalid, 1);
      serve(0, 32'h1020, 1);

      // Channel stall holds AR; a write to another line does not
      stall[1]      = 1'b1;
      write_process = 1'b1;
      write_address = 32'h5000;
      set_req(1, 32'h4000, 8'd1);
      @(negedge clk);
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         chk("stall_hold", axi_req.arvalid, 0);
         @(negedge clk);
      end
      stall = '0;
      @(negedge clk);
      chk("stall_release", axi_req.arvalid, 1);
      serve(1, 32'h4000, 2);
      write_process = 1'b0;

      // Fill ch0 while AXI is idle; ninth push dropped
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_req(0, 32'h2000 + 32'(k) * 32'h40, 8'd0);
         @(negedge clk);
         chk("fill_ready", req_ready[0], (k < 7) ? 1 : 0);
      end
      set_req(0, 32'h9000, 8'd0);
      @(negedge clk);
      req_valid = '0;
      chk("full_ready", req_ready, 2'b10);
      chk("full_arvalid_held", axi_req.arvalid, 1);
      for (int k = 0; k < 8; k++) serve(0, 32'h2000 + 32'(k) * 32'h40, 1);
      for (int i = 0; i < 6; i++) @(negedge clk);
      chk("drained_arvalid", axi_req.arvalid, 0);
      chk("drained_empty", empty, 2'b11);

      // Ninth burst on ch0 wraps seq back to 0
      set_req(0, 32'h3000, 8'd0);
      @(negedge clk);
      req_valid = '0;
      chk("wrap_seq_model", exp_seq[0], 0);
      serve(0, 32'h3000, 1);

      // Reset during beat 5 of 16 abandons the burst
      set_req(0, 32'h6000, 8'd15);
      @(negedge clk);
      req_valid = '0;
      wait_ar();
      axi_resp.arready = 1'b1;
      @(negedge clk);
      axi_resp.arready = 1'b0;
      axi_resp.rvalid  = 1'b1;
      for (int b = 0; b < 4; b++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N_CH; i++) exp_seq[i] = 0;
      chk("midrst_empty", empty, 2'b11);
      chk("midrst_ready", req_ready, 2'b11);
      chk("midrst_arvalid", axi_req.arvalid, 0);
      for (int b = 5; b < 16; b++) begin
         axi_resp.rlast = (b == 15);
         #1 chk("stray_valid", resp.valid, 0);
         @(negedge clk);
      end
      axi_resp.rvalid = 1'b0;
      axi_resp.rlast  = 1'b0;
      chk("stray_end", end_pulse, 0);
      chk("stray_empty", empty, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_read_arb.md
MEM_READ_ARB -- requirements
Module: mem_read_arb

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, per-channel request queue depth (power of 2).
REQ-003 SHALL have parameter SEQ_W, default 3, per-channel ID sequence width; arid = {channel index, seq}.
REQ-004 SHALL have parameter LINE_BYTE_OFFSET, default 6, cache-line offset bits for the write-hazard compare.
REQ-005 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: i_req in mem_read_req[N_CH] request; i_req_valid in [N_CH]; o_req_ready out [N_CH].
REQ-007 SHALL have ports: i_stall in [N_CH] channel AR hold; i_write_process in 1; i_write_address in 32.
REQ-008 SHALL have ports: o_resp out mem_read_resp (data, last, firstaddr, firstva, valid[N_CH]); o_start out [N_CH]; o_end out [N_CH]; o_empty out [N_CH].
REQ-009 SHALL have ports: axi_bus_req out axi_r_req; axi_bus_resp in axi_r_resp.

Function
REQ-010 Request SHALL be accepted on i_req_valid && o_req_ready; o_req_ready = registered !full of that channel's queue, no same-cycle pop bypass.
REQ-011 FSM states SHALL be IDLE, AR_WAIT, AR, R; single outstanding burst.
REQ-012 IDLE: if any queue non-empty, SHALL latch grant channel and go AR_WAIT next cycle; else stay.
REQ-013 Arbitration SHALL be round-robin, starting after the last granted channel.
REQ-014 AR_WAIT -> AR SHALL occur when !i_stall[grant] && !(i_write_process && i_write_address[31:LINE_BYTE_OFFSET] == head.startaddr[31:LINE_BYTE_OFFSET]); otherwise hold.
REQ-015 arvalid SHALL be 1 only in AR, never deasserted before arready; hazard/stall not re-evaluated in AR.
REQ-016 araddr/arlen/arsize SHALL come from the granted queue head; arburst 2'b10, arlock/arcache/arprot 0, rready 1.
REQ-017 o_start[grant] SHALL pulse for the AR->R transition cycle (arvalid && arready).
REQ-018 On AR handshake, firstaddr/firstva SHALL load head startaddr/va; each rvalid beat in R adds 4 to both.
REQ-019 o_resp.valid[grant] = rvalid && state==R; all other valid bits 0; rvalid outside R SHALL be ignored.
REQ-020 rvalid && rlast in R SHALL pop grant queue, increment its seq (wrap 2^SEQ_W-1 -> 0), go IDLE; o_end[grant] pulses the following cycle.
REQ-021 Per-channel count SHALL +1 on accept, -1 on pop, unchanged on simultaneous; o_empty[ch] = (count == 0), counting in-flight bursts.
REQ-022 Full queue: o_req_ready low; push ignored; count never exceeds FIFO_DEPTH.
REQ-023 Minimum latency: accept at edge E0 -> AR_WAIT after E1 -> arvalid after E2 when unblocked.

Reset
REQ-024 On i_rst: state IDLE, queues empty, counts 0, seq 0, round-robin pointer to channel 0, firstaddr/firstva 0.
REQ-025 Reset outputs: arvalid 0, o_start 0, o_end 0, o_resp.valid 0, o_empty all 1, o_req_ready all 1 from the first cycle after reset.
REQ-026 Reset mid-burst SHALL abandon the burst; later stray R beats SHALL be ignored per REQ-019.

Configuration
REQ-027 Macro MEM_READ_ARB_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, highest index wins; round-robin pointer removed.
REQ-028 Macro undefined: round-robin per REQ-013.

Structure
REQ-029 Shared package SHALL hold mem_read_req, mem_read_resp (valid as vector), axi_r_req/resp, FSM state enum, fixed burst constants.
REQ-030 One sub-module mem_read_chan_fifo (sync FIFO, push/pop/full/empty/head), instantiated N_CH times.

Verification
REQ-031 Ch0 single req addr 0x1000 len 15 -> arvalid after E2, arid={0,0}; 16 beats valid[0]; firstaddr 0x1000..0x103C; o_end[0] once.
REQ-032 Ch0 and ch1 both pending, round-robin -> grants 0,1,0,1; with FIXED_PRIO_EN -> all ch1 requests first.
REQ-033 i_write_process, write addr 0x1004, head addr 0x1020 -> AR held in AR_WAIT; write drops -> arvalid next cycle.
REQ-034 Fill ch0 with 8 reqs, AXI idle -> o_req_ready[0]=0, ninth push dropped, count 8.
REQ-035 i_rst asserted during beat 5 of 16 -> IDLE, counts 0, remaining beats produce no valid.
REQ-036 Nine ch0 bursts -> arid seq 0..7 then wraps to 0.
